jtdsp16_pmem: RTL

- Program-memory responder for the XAAU.
- Answers instruction fetches on rom_addr and *pt++ table reads on pt_addr.
- Serves both from an internal dual-read ROM, or from an external memory through a req/ok handshake.
- Asserts stall while an external access is in flight; the top level gates the core with cen & ~stall.

---
 rtl/jtdsp16_pmem_pkg.sv | 15 +
 rtl/jtdsp16_pmem_dpram.sv | 27 ++
 rtl/jtdsp16_pmem.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/jtdsp16_pmem_pkg.sv
// Shared types and defaults for the DSP16 program-memory responder.
// FSM state encoding and default internal ROM address width.
package jtdsp16_pmem_pkg;

    localparam int IROM_AW_DEF = 12;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PT_REQ  = 3'd1,
        GAP     = 3'd2,
        PC_REQ  = 3'd3,
        RELEASE = 3'd4
    } pmem_state_t;

endpackage

// File: rtl/jtdsp16_pmem_dpram.sv
// Internal program ROM: one write port (download) and two
// synchronous read ports (instruction fetch and table read).
module jtdsp16_pmem_dpram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic          rd_a,
    input  logic [AW-1:0] addr_a,
    output logic [15:0]   q_a,
    input  logic          rd_b,
    input  logic [AW-1:0] addr_b,
    output logic [15:0]   q_b
);

    logic [15:0] mem [0:(2**AW)-1];

    // Reads see the word stored before a same-edge write.
    always_ff @(posedge clk) begin
        if (we)   mem[waddr] <= wdata;
        if (rd_a) q_a        <= mem[addr_a];
        if (rd_b) q_b        <= mem[addr_b];
    end

endmodule

// File: rtl/jtdsp16_pmem.sv
// Program-memory responder: serves fetches and *pt++ reads from the
// internal ROM or, on a miss, from external memory via req/ok.
module jtdsp16_pmem
    import jtdsp16_pmem_pkg::*;
#(
    parameter int IROM_AW = IROM_AW_DEF,
    parameter int EXT_GAP = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               exm,
    input  logic [15:0]        rom_addr,
    output logic [15:0]        rom_dout,
    input  logic               pt_read,
    input  logic [15:0]        pt_addr,
    output logic [15:0]        pt_dout,
    output logic               stall,
    output logic               ext_cs,
    output logic [15:0]        ext_addr,
    input  logic [15:0]        ext_data,
    input  logic               ext_ok,
    input  logic               prog_we,
    input  logic [IROM_AW-1:0] prog_addr,
    input  logic [15:0]        prog_data
);

    localparam int GW = (EXT_GAP > 1) ? $clog2(EXT_GAP) : 1;

    pmem_state_t   state;
    logic [GW-1:0] gap_cnt;
    logic          pc_ext, pt_ext, miss, idle;
    logic          pc_ext_l, pt_ext_l, pt_read_l, cap;
    logic [15:0]   pc_addr_l;
    logic [15:0]   pc_hold, pt_hold;
    logic [15:0]   rom_q, pt_q, ram_qa, ram_qb;
    logic          rom_sel, pt_sel;
    logic          rd_a, rd_b;

    assign pc_ext = exm | (rom_addr[15:IROM_AW] != '0);
    assign pt_ext = pt_read & (exm | (pt_addr[15:IROM_AW] != '0));
    assign miss   = pc_ext | pt_ext;
    assign idle   = state == IDLE;

    assign stall = ~rst & ((idle & cen & miss) |
                   (state != IDLE && state != RELEASE));

    assign rd_a = idle & cen & ~pc_ext;
    assign rd_b = idle & cen & pt_read & ~pt_ext;

    // Outputs come straight from the RAM register after a hit, and
    // from the local copy while a miss is being served.
    assign rom_dout = rom_sel ? rom_q : ram_qa;
    assign pt_dout  = pt_sel  ? pt_q  : ram_qb;

    jtdsp16_pmem_dpram #(.AW(IROM_AW)) u_ram (
        .clk    (clk),
        .we     (prog_we),
        .waddr  (prog_addr),
        .wdata  (prog_data),
        .rd_a   (rd_a),
        .addr_a (rom_addr[IROM_AW-1:0]),
        .q_a    (ram_qa),
        .rd_b   (rd_b),
        .addr_b (pt_addr[IROM_AW-1:0]),
        .q_b    (ram_qb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            ext_cs    <= 1'b0;
            ext_addr  <= '0;
            pc_ext_l  <= 1'b0;
            pt_ext_l  <= 1'b0;
            pt_read_l <= 1'b0;
            pc_addr_l <= '0;
            cap       <= 1'b0;
            pc_hold   <= '0;
            pt_hold   <= '0;
            rom_q     <= '0;
            pt_q      <= '0;
            rom_sel   <= 1'b1;
            pt_sel    <= 1'b1;
        end else begin
            cap <= 1'b0;
            // Internal half of a mixed request lands one cycle later.
            if (cap) begin
                if (!pc_ext_l)             pc_hold <= ram_qa;
                if (pt_read_l && !pt_ext_l) pt_hold <= ram_qb;
            end
            unique case (state)
                IDLE: begin
                    if (cen && miss) begin
                        pc_ext_l  <= pc_ext;
                        pt_ext_l  <= pt_ext;
                        pt_read_l <= pt_read;
                        pc_addr_l <= rom_addr;
                        cap       <= 1'b1;
                        rom_q     <= rom_dout;
                        pt_q      <= pt_dout;
                        rom_sel   <= 1'b1;
                        pt_sel    <= 1'b1;
                        ext_cs    <= 1'b1;
                        if (pt_ext) begin
                            state    <= PT_REQ;
                            ext_addr <= pt_addr;
                        end else begin
                            state    <= PC_REQ;
                            ext_addr <= rom_addr;
                        end
                    end else if (cen) begin
                        rom_sel <= 1'b0;
                        if (pt_read) pt_sel <= 1'b0;
                    end
                end
                PT_REQ: begin
                    if (ext_ok) begin
                        pt_hold <= ext_data;
                        ext_cs  <= 1'b0;
                        if (pc_ext_l) begin
                            state   <= GAP;
                            gap_cnt <= GW'(EXT_GAP - 1);
                        end else begin
                            state <= RELEASE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state    <= PC_REQ;
                        ext_cs   <= 1'b1;
                        ext_addr <= pc_addr_l;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                PC_REQ: begin
                    if (ext_ok) begin
                        pc_hold <= ext_data;
                        ext_cs  <= 1'b0;
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (cen) begin
                        rom_q <= pc_hold;
                        if (pt_read_l) pt_q <= pt_hold;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
